// File: rtl/cim_tile_sequencer.sv
// Sequences weight loads, K-tile accumulation and result drain on a Basic GeMM CIM macro port.
// Latency: strobes one cycle after each src handshake; each result CIM_LAT+1 cycles after its select.
// Backpressure: src_valid low stalls with no strobes; res_ready low holds res_* and cim_output_reg. Option: CIM_SEQ_RELU_EN.
module cim_tile_sequencer #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int ROWS    = 16,
    parameter int OUTS    = 16,
    parameter int OREG_W  = 4,
    parameter int TILE_W  = 8,
    parameter int CIM_LAT = 1
) (
    input  logic              CLK,
    input  logic              RESN,
    input  logic              start,
    input  logic [TILE_W-1:0] cfg_tiles,
    output logic              busy,
    output logic              done,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic [DATA_W-1:0] src_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [OREG_W-1:0] res_idx,
    output logic              cim_write,
    output logic              cim_en,
    output logic              cim_partial_sum,
    output logic              cim_reset_output,
    output logic [OREG_W-1:0] cim_output_reg,
    output logic [ADDR_W-1:0] cim_address,
    output logic [DATA_W-1:0] cim_input_data,
    input  logic [DATA_W-1:0] cim_output
);

    localparam int ROW_W = $clog2(ROWS + 1);
    localparam int J_W   = $clog2(OUTS + 1);
    localparam int LAT_W = $clog2(CIM_LAT + 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [J_W-1:0]   J_LAST   = J_W'(OUTS - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(CIM_LAT);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_COMPUTE, S_DRAIN_SEL, S_DRAIN_OUT, S_CLEAR, S_DONE
    } state_t;

    state_t            state, state_nx;
    logic [ROW_W-1:0]  row;
    logic [J_W-1:0]    j;
    logic [TILE_W-1:0] tile, tiles;
    logic [LAT_W-1:0]  lat;
    logic              last_row, last_out, last_tile;
    logic [DATA_W-1:0] cap_val;

    assign last_row  = (row == ROW_LAST);
    assign last_out  = (j == J_LAST);
    assign last_tile = (tile == tiles - TILE_W'(1));

`ifdef CIM_SEQ_RELU_EN
    // Signed ReLU applied at capture time: negative results clamp to zero.
    assign cap_val = cim_output[DATA_W-1] ? '0 : cim_output;
`else
    assign cap_val = cim_output;
`endif

    // State register.
    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state decode and state-derived handshake/status outputs.
    always_comb begin
        state_nx  = state;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        src_ready = (state == S_LOAD_W) || (state == S_COMPUTE);
        res_valid = (state == S_DRAIN_OUT);
        case (state)
            S_IDLE:      if (start) state_nx = (cfg_tiles == '0) ? S_DONE : S_LOAD_W;
            S_LOAD_W:    if (src_valid && last_row) state_nx = S_COMPUTE;
            S_COMPUTE:   if (src_valid && last_out) state_nx = last_tile ? S_DRAIN_SEL : S_LOAD_W;
            S_DRAIN_SEL: if (lat == LAT_LAST) state_nx = S_DRAIN_OUT;
            S_DRAIN_OUT: if (res_ready) state_nx = last_out ? S_CLEAR : S_DRAIN_SEL;
            S_CLEAR:     state_nx = S_DONE;
            S_DONE:      state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    // Counters, registered CIM strobes and result capture.
    // The first DRAIN_SEL cycle only loads the select (it may coincide with the
    // final cim_en strobe); the select is then held CIM_LAT cycles before capture.
    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) begin
            row              <= '0;
            j                <= '0;
            tile             <= '0;
            tiles            <= '0;
            lat              <= '0;
            cim_write        <= 1'b0;
            cim_en           <= 1'b0;
            cim_partial_sum  <= 1'b0;
            cim_reset_output <= 1'b0;
            cim_output_reg   <= '0;
            cim_address      <= '0;
            cim_input_data   <= '0;
            res_data         <= '0;
            res_idx          <= '0;
        end else begin
            cim_write        <= 1'b0;
            cim_en           <= 1'b0;
            cim_partial_sum  <= 1'b0;
            cim_reset_output <= (state_nx == S_CLEAR);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        tiles <= cfg_tiles;
                        tile  <= '0;
                        row   <= '0;
                        j     <= '0;
                    end
                end
                S_LOAD_W: begin
                    if (src_valid) begin
                        cim_write      <= 1'b1;
                        cim_address    <= ADDR_W'(row);
                        cim_input_data <= src_data;
                        if (last_row) begin
                            row <= '0;
                            j   <= '0;
                        end else begin
                            row <= row + ROW_W'(1);
                        end
                    end
                end
                S_COMPUTE: begin
                    if (src_valid) begin
                        cim_en          <= 1'b1;
                        cim_output_reg  <= OREG_W'(j);
                        cim_input_data  <= src_data;
                        cim_partial_sum <= (tile != '0);
                        if (last_out) begin
                            j    <= '0;
                            tile <= tile + TILE_W'(1);
                            lat  <= '0;
                        end else begin
                            j <= j + J_W'(1);
                        end
                    end
                end
                S_DRAIN_SEL: begin
                    if (lat == '0) cim_output_reg <= OREG_W'(j);
                    if (lat == LAT_LAST) begin
                        res_data <= cap_val;
                        res_idx  <= OREG_W'(j);
                    end else begin
                        lat <= lat + LAT_W'(1);
                    end
                end
                S_DRAIN_OUT: begin
                    if (res_ready) begin
                        lat <= '0;
                        j   <= last_out ? '0 : j + J_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
